// File: rtl/kf8259_interrupt_request.sv
// ---------------------------------------------------------------------------
// kf8259_interrupt_request
//
// Interrupt Request Register (IRR) stage of the KF8259 interrupt controller.
// It samples the eight IR pins in level-triggered or edge-triggered mode and
// holds the pending requests in an 8-bit register. The priority and
// in-service logic can clear individual bits. The register can also be frozen
// so it stays stable during an interrupt-acknowledge sequence.
//
// Ports:
//   clock                      in   1  system clock, rising-edge active
//   reset                      in   1  synchronous active-high reset
//   level_toriggered_config    in   1  1 = level mode, 0 = edge mode (LTIM)
//   freeze                     in   1  1 = hold IRR contents (INTA in progress)
//   clear_interrupt_request    in   8  per-bit clear for IRR and edge arm latch
//   interrupt_request_pin      in   8  IR0..IR7 request inputs, active high
//   interrupt_request_register out  8  registered IRR
//
// Optional build macro:
//   KF8259_IRQ_INPUT_SYNC_EN - when defined, the IR pins pass through a
//   2-flop synchronizer before any other logic. This makes the pin-to-IRR
//   latency 3 clocks. When undefined, the pins are used directly and the
//   latency is 1 clock.
// ---------------------------------------------------------------------------
module kf8259_interrupt_request (
  input  logic       clock,
  input  logic       reset,
  input  logic       level_toriggered_config,
  input  logic       freeze,
  input  logic [7:0] clear_interrupt_request,
  input  logic [7:0] interrupt_request_pin,
  output logic [7:0] interrupt_request_register
);

  logic [7:0] w_pin;
  logic [7:0] w_edge;
  logic [7:0] w_modeNext;
  logic [7:0] w_irrNext;
  logic [7:0] r_arm;
  logic [7:0] r_irr;

`ifdef KF8259_IRQ_INPUT_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  // Two-stage synchronizer for the asynchronous IR pins. Everything
  // downstream, including the arm latches, sees only the synchronized copy.
  // A short low pulse therefore arms a bit only if it survives both stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= interrupt_request_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pin = r_sync2;
`else
  assign w_pin = interrupt_request_pin;
`endif

  // Edge arm latch. A bit becomes armed once its pin has been seen low, and a
  // clear disarms it. This is why a pin that stays high through a clear
  // cannot re-request until it drops and rises again. Freeze does not affect
  // the latch, and the latch keeps running in level mode as well.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_arm <= 8'h00;
    end else begin
      r_arm <= (r_arm | ~w_pin) & ~clear_interrupt_request;
    end
  end

  // A rising edge is an armed bit whose pin is now high. In edge mode the
  // IRR bit stays set while the pin is held high after the rise: the arm
  // latch holds its value while the pin is high, so w_edge stays asserted.
  assign w_edge = r_arm & w_pin;

  // Next IRR value. Clear has the highest priority, then freeze, then the
  // mode rule selects either the raw pin or the armed edge.
  always_comb begin
    w_modeNext = level_toriggered_config ? w_pin : w_edge;
    w_irrNext  = freeze ? r_irr : w_modeNext;
    w_irrNext  = w_irrNext & ~clear_interrupt_request;
  end

  // IRR register. The output is taken straight from this register, so there
  // is no combinational path from the inputs to the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irr <= 8'h00;
    end else begin
      r_irr <= w_irrNext;
    end
  end

  assign interrupt_request_register = r_irr;

endmodule

// File: tb/tb_kf8259_interrupt_request.sv
// ---------------------------------------------------------------------------
// tb_kf8259_interrupt_request
//
// Self-checking bench for the KF8259 IRR stage in its default build, where
// the pins go directly to the logic. Directed scenarios compare the output
// against hand-derived constants. A randomized phase compares it against a
// per-line behavioural model of the request rules.
// ---------------------------------------------------------------------------
module tb_kf8259_interrupt_request;

  logic       clock;
  logic       reset;
  logic       level_toriggered_config;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_request_pin;
  logic [7:0] interrupt_request_register;

  int checks;
  int errors;

  // Behavioural model state: one armed flag and one pending flag per IR line.
  bit modelArm [8];
  bit modelIrr [8];

  kf8259_interrupt_request dut (
    .clock                      (clock),
    .reset                      (reset),
    .level_toriggered_config    (level_toriggered_config),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_interrupt_request),
    .interrupt_request_pin      (interrupt_request_pin),
    .interrupt_request_register (interrupt_request_register)
  );

  // Free-running clock with a 10-time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs the model's per-line pending flags into a byte for comparison.
  function automatic logic [7:0] modelValue();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v[i] = modelIrr[i];
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently driven. Each
  // line is handled on its own, following the request rules line by line.
  task automatic modelClock();
    bit nextArm [8];
    bit nextIrr [8];
    for (int i = 0; i < 8; i++) begin
      bit pinHigh;
      bit clr;
      bit rose;
      pinHigh = interrupt_request_pin[i];
      clr     = clear_interrupt_request[i];
      rose    = modelArm[i] && pinHigh;
      if (reset) begin
        nextArm[i] = 0;
        nextIrr[i] = 0;
      end else begin
        if (clr)           nextArm[i] = 0;
        else if (!pinHigh) nextArm[i] = 1;
        else               nextArm[i] = modelArm[i];

        if (clr)                          nextIrr[i] = 0;
        else if (freeze)                  nextIrr[i] = modelIrr[i];
        else if (level_toriggered_config) nextIrr[i] = pinHigh;
        else                              nextIrr[i] = rose;
      end
    end
    for (int i = 0; i < 8; i++) begin
      modelArm[i] = nextArm[i];
      modelIrr[i] = nextIrr[i];
    end
  endtask

  // Applies the driven inputs for one clock. The model is updated alongside
  // the clock edge, and the task returns 1 time unit after the edge, which is
  // where the output is sampled.
  task automatic applyStimulus();
    modelClock();
    @(posedge clock);
    #1;
  endtask

  // Reset state: IRR must read 8'h00.
  task automatic test_reset();
    reset = 1'b1;
    level_toriggered_config = 1'b1;
    freeze = 1'b0;
    clear_interrupt_request = 8'h00;
    interrupt_request_pin = 8'h00;
    applyStimulus();
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", interrupt_request_register, 8'h00);
    end
    reset = 1'b0;
  endtask

  // Level mode: the bit sets one clock after the pin, a clear drops it for
  // that cycle, and it reloads because the pin is still high.
  task automatic test_level_basic();
    level_toriggered_config = 1'b1;
    interrupt_request_pin = 8'h01;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h01) begin
      errors++;
      $display("[TB] FAIL level_set: got %h expected %h", interrupt_request_register, 8'h01);
    end
    clear_interrupt_request = 8'h01;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL level_clear: got %h expected %h", interrupt_request_register, 8'h00);
    end
    clear_interrupt_request = 8'h00;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h01) begin
      errors++;
      $display("[TB] FAIL level_reload: got %h expected %h", interrupt_request_register, 8'h01);
    end
  endtask

  // Level mode: a walking one on the pins is mirrored on the IRR one clock
  // later, and releasing all the pins empties the IRR.
  task automatic test_level_walk();
    logic [7:0] pattern;
    for (int i = 0; i < 8; i++) begin
      pattern = 8'h01 << i;
      interrupt_request_pin = pattern;
      applyStimulus();
      checks++;
      if (interrupt_request_register !== pattern) begin
        errors++;
        $display("[TB] FAIL level_walk_%0d: got %h expected %h", i, interrupt_request_register, pattern);
      end
    end
    interrupt_request_pin = 8'h00;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL level_release: got %h expected %h", interrupt_request_register, 8'h00);
    end
  endtask

  // Edge mode: low then high requests the line. A clear disarms it, so a
  // held-high pin stays silent until it goes low and then high again.
  task automatic test_edge();
    level_toriggered_config = 1'b0;
    interrupt_request_pin = 8'h00;
    applyStimulus();
    interrupt_request_pin = 8'h80;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h80) begin
      errors++;
      $display("[TB] FAIL edge_rise: got %h expected %h", interrupt_request_register, 8'h80);
    end
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h80) begin
      errors++;
      $display("[TB] FAIL edge_hold: got %h expected %h", interrupt_request_register, 8'h80);
    end
    clear_interrupt_request = 8'h80;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL edge_clear: got %h expected %h", interrupt_request_register, 8'h00);
    end
    clear_interrupt_request = 8'h00;
    applyStimulus();
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL edge_disarmed: got %h expected %h", interrupt_request_register, 8'h00);
    end
    interrupt_request_pin = 8'h00;
    applyStimulus();
    interrupt_request_pin = 8'h80;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h80) begin
      errors++;
      $display("[TB] FAIL edge_rearm: got %h expected %h", interrupt_request_register, 8'h80);
    end
    interrupt_request_pin = 8'h00;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL edge_drop: got %h expected %h", interrupt_request_register, 8'h00);
    end
  endtask

  // Edge mode: bit 4 was armed earlier while its pin was low. After a clear,
  // a pin held steady high must never request, because it has not been low
  // since the clear.
  task automatic test_edge_no_low();
    level_toriggered_config = 1'b0;
    interrupt_request_pin = 8'h10;
    clear_interrupt_request = 8'h10;
    applyStimulus();
    clear_interrupt_request = 8'h00;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checks++;
      if (interrupt_request_register !== 8'h00) begin
        errors++;
        $display("[TB] FAIL edge_no_low_%0d: got %h expected %h", k, interrupt_request_register, 8'h00);
      end
    end
  endtask

  // Freeze: pin changes are ignored while frozen, a clear still wins, and
  // the mode rule resumes on the next cycle after the freeze is released.
  task automatic test_freeze();
    level_toriggered_config = 1'b1;
    interrupt_request_pin = 8'h04;
    applyStimulus();
    freeze = 1'b1;
    interrupt_request_pin = 8'h40;
    applyStimulus();
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h04) begin
      errors++;
      $display("[TB] FAIL freeze_hold: got %h expected %h", interrupt_request_register, 8'h04);
    end
    clear_interrupt_request = 8'h04;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL freeze_clear: got %h expected %h", interrupt_request_register, 8'h00);
    end
    clear_interrupt_request = 8'h00;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL freeze_still: got %h expected %h", interrupt_request_register, 8'h00);
    end
    freeze = 1'b0;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h40) begin
      errors++;
      $display("[TB] FAIL freeze_release: got %h expected %h", interrupt_request_register, 8'h40);
    end
  endtask

  // Reset in mid-operation: it overrides freeze and the pins, and it clears
  // the arm latches, so in edge mode held-high pins must not request.
  task automatic test_reset_mid();
    level_toriggered_config = 1'b1;
    interrupt_request_pin = 8'hFF;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: got %h expected %h", interrupt_request_register, 8'hFF);
    end
    reset = 1'b1;
    freeze = 1'b1;
    applyStimulus();
    checks++;
    if (interrupt_request_register !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h expected %h", interrupt_request_register, 8'h00);
    end
    reset = 1'b0;
    freeze = 1'b0;
    level_toriggered_config = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checks++;
      if (interrupt_request_register !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_disarm_%0d: got %h expected %h", k, interrupt_request_register, 8'h00);
      end
    end
  endtask

  // Randomized phase: mixed modes, freezes, sparse clears, occasional
  // resets and toggling pins, all checked against the behavioural model.
  task automatic test_random();
    logic [7:0] expected;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) level_toriggered_config = ~level_toriggered_config;
      clear_interrupt_request = ($urandom_range(0, 2) == 0) ?
                                (8'($urandom) & 8'($urandom)) : 8'h00;
      interrupt_request_pin = interrupt_request_pin ^ (8'($urandom) & 8'($urandom));
      applyStimulus();
      expected = modelValue();
      checks++;
      if (interrupt_request_register !== expected) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h expected %h", n, interrupt_request_register, expected);
      end
    end
    reset = 1'b0;
    freeze = 1'b0;
    clear_interrupt_request = 8'h00;
  endtask

  // Runs each scenario in order, then prints the single summary line.
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) begin
      modelArm[i] = 0;
      modelIrr[i] = 0;
    end
    reset = 1'b1;
    level_toriggered_config = 1'b1;
    freeze = 1'b0;
    clear_interrupt_request = 8'h00;
    interrupt_request_pin = 8'h00;
    test_reset();
    test_level_basic();
    test_level_walk();
    test_edge();
    test_edge_no_low();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
